// File: rtl/wisc_pkg.sv
// Shared WISC core definitions: opcodes, branch condition codes and the
// per-opcode flag-update classification.
package wisc_pkg;

    localparam int unsigned OPW = 4;
    localparam int unsigned CCW = 3;

    localparam logic [OPW-1:0] OP_ADD    = 4'b0000;
    localparam logic [OPW-1:0] OP_SUB    = 4'b0001;
    localparam logic [OPW-1:0] OP_XOR    = 4'b0010;
    localparam logic [OPW-1:0] OP_RED    = 4'b0011;
    localparam logic [OPW-1:0] OP_SLL    = 4'b0100;
    localparam logic [OPW-1:0] OP_SRA    = 4'b0101;
    localparam logic [OPW-1:0] OP_ROR    = 4'b0110;
    localparam logic [OPW-1:0] OP_PADDSB = 4'b0111;
    localparam logic [OPW-1:0] OP_LW     = 4'b1000;
    localparam logic [OPW-1:0] OP_SW     = 4'b1001;
    localparam logic [OPW-1:0] OP_LLB    = 4'b1010;
    localparam logic [OPW-1:0] OP_LHB    = 4'b1011;
    localparam logic [OPW-1:0] OP_B      = 4'b1100;
    localparam logic [OPW-1:0] OP_BR     = 4'b1101;
    localparam logic [OPW-1:0] OP_PCS    = 4'b1110;
    localparam logic [OPW-1:0] OP_HLT    = 4'b1111;

    localparam logic [CCW-1:0] CC_NE  = 3'b000;
    localparam logic [CCW-1:0] CC_EQ  = 3'b001;
    localparam logic [CCW-1:0] CC_GT  = 3'b010;
    localparam logic [CCW-1:0] CC_LT  = 3'b011;
    localparam logic [CCW-1:0] CC_GTE = 3'b100;
    localparam logic [CCW-1:0] CC_LTE = 3'b101;
    localparam logic [CCW-1:0] CC_OV  = 3'b110;
    localparam logic [CCW-1:0] CC_UNC = 3'b111;

    typedef enum logic [1:0] {
        FLG_NONE   = 2'd0,
        FLG_Z_ONLY = 2'd1,
        FLG_ALL    = 2'd2
    } flag_class_e;

    // Which architectural flags an opcode writes when it retires from EX.
    function automatic flag_class_e flag_class(input logic [OPW-1:0] op);
        flag_class_e cls;
        case (op)
            OP_ADD, OP_SUB:                 cls = FLG_ALL;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: cls = FLG_Z_ONLY;
            default:                        cls = FLG_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator: ccc field plus Z/V/N to taken.
// Shared with decode.
module branch_cond_eval
    import wisc_pkg::*;
(
    input  logic [CCW-1:0] i_ccc,
    input  logic           i_z,
    input  logic           i_v,
    input  logic           i_n,
    output logic           o_taken_c
);

    always_comb begin
        o_taken_c = 1'b0;
        case (i_ccc)
            CC_NE:   o_taken_c = ~i_z;
            CC_EQ:   o_taken_c = i_z;
            CC_GT:   o_taken_c = ~i_z & ~i_n;
            CC_LT:   o_taken_c = i_n;
            CC_GTE:  o_taken_c = i_z | (~i_z & ~i_n);
            CC_LTE:  o_taken_c = i_n | i_z;
            CC_OV:   o_taken_c = i_v;
            CC_UNC:  o_taken_c = 1'b1;
            default: o_taken_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline register plus the architectural Z/V/N flag register.
// FLAG_BYPASS_EN: branch evaluation sees next-state flags of a flag-setter in EX.
module ex_mem_flag_stage
    import wisc_pkg::*;
#(
    parameter int unsigned DW = 16,
    parameter int unsigned RW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ex_valid,
    input  logic [OPW-1:0] ex_opcode,
    input  logic [DW-1:0]  ex_result,
    input  logic           ex_ovfl,
    input  logic [RW-1:0]  ex_dst,
    input  logic           ex_wr_en,
    input  logic           stall,
    input  logic           flush,
    input  logic [CCW-1:0] br_cond,
    output logic           mem_valid,
    output logic [OPW-1:0] mem_opcode,
    output logic [DW-1:0]  mem_result,
    output logic [RW-1:0]  mem_dst,
    output logic           mem_wr_en,
    output logic           flag_z,
    output logic           flag_v,
    output logic           flag_n,
    output logic           br_taken
);

    logic           r_valid;
    logic [OPW-1:0] r_opcode;
    logic [DW-1:0]  r_result;
    logic [RW-1:0]  r_dst;
    logic           r_wr_en;
    logic           r_z;
    logic           r_v;
    logic           r_n;

    logic           w_flag_upd;
    flag_class_e    w_class;
    logic           w_z_nxt;
    logic           w_v_nxt;
    logic           w_n_nxt;
    logic           w_br_z;
    logic           w_br_v;
    logic           w_br_n;

    assign w_flag_upd = ex_valid & ~stall & ~flush;
    assign w_class    = flag_class(ex_opcode);

    // Next-state flags; held bits fall through from the register.
    always_comb begin
        w_z_nxt = r_z;
        w_v_nxt = r_v;
        w_n_nxt = r_n;
        if (w_flag_upd) begin
            case (w_class)
                FLG_ALL: begin
                    w_z_nxt = (ex_result == '0);
                    w_v_nxt = ex_ovfl;
                    w_n_nxt = ex_result[DW-1];
                end
                FLG_Z_ONLY: begin
                    w_z_nxt = (ex_result == '0);
                end
                default: begin
                    w_z_nxt = r_z;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_opcode <= '0;
            r_result <= '0;
            r_dst    <= '0;
            r_wr_en  <= 1'b0;
            r_z      <= 1'b0;
            r_v      <= 1'b0;
            r_n      <= 1'b0;
        end else if (!stall) begin
            r_valid  <= ex_valid & ~flush;
            r_wr_en  <= ex_valid & ex_wr_en & ~flush;
            r_opcode <= ex_opcode;
            r_result <= ex_result;
            r_dst    <= ex_dst;
            r_z      <= w_z_nxt;
            r_v      <= w_v_nxt;
            r_n      <= w_n_nxt;
        end
    end

`ifdef FLAG_BYPASS_EN
    assign w_br_z = w_z_nxt;
    assign w_br_v = w_v_nxt;
    assign w_br_n = w_n_nxt;
`else
    assign w_br_z = r_z;
    assign w_br_v = r_v;
    assign w_br_n = r_n;
`endif

    branch_cond_eval u_br_eval (
        .i_ccc     (br_cond),
        .i_z       (w_br_z),
        .i_v       (w_br_v),
        .i_n       (w_br_n),
        .o_taken_c (br_taken)
    );

    assign mem_valid  = r_valid;
    assign mem_opcode = r_opcode;
    assign mem_result = r_result;
    assign mem_dst    = r_dst;
    assign mem_wr_en  = r_wr_en;
    assign flag_z     = r_z;
    assign flag_v     = r_v;
    assign flag_n     = r_n;

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Directed vector bench for ex_mem_flag_stage; honours FLAG_BYPASS_EN.
module tb_ex_mem_flag_stage;
    import wisc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [15:0] ex_result;
    logic        ex_ovfl;
    logic [3:0]  ex_dst;
    logic        ex_wr_en;
    logic        stall;
    logic        flush;
    logic [2:0]  br_cond;
    logic        mem_valid;
    logic [3:0]  mem_opcode;
    logic [15:0] mem_result;
    logic [3:0]  mem_dst;
    logic        mem_wr_en;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;
    logic        br_taken;

    int n_checks = 0;
    int n_fail   = 0;

    ex_mem_flag_stage #(.DW(16), .RW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_opcode  (ex_opcode),
        .ex_result  (ex_result),
        .ex_ovfl    (ex_ovfl),
        .ex_dst     (ex_dst),
        .ex_wr_en   (ex_wr_en),
        .stall      (stall),
        .flush      (flush),
        .br_cond    (br_cond),
        .mem_valid  (mem_valid),
        .mem_opcode (mem_opcode),
        .mem_result (mem_result),
        .mem_dst    (mem_dst),
        .mem_wr_en  (mem_wr_en),
        .flag_z     (flag_z),
        .flag_v     (flag_v),
        .flag_n     (flag_n),
        .br_taken   (br_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [3:0]  op;
        logic [15:0] res;
        logic        ovfl;
        logic [3:0]  dst;
        logic        wr;
        logic        stl;
        logic        fls;
        logic        chk_data;
        logic        e_valid;
        logic [3:0]  e_op;
        logic [15:0] e_res;
        logic [3:0]  e_dst;
        logic        e_wr;
        logic [2:0]  e_zvn;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res, input logic ovfl,
                         input logic [3:0] dst, input logic wr, input logic stl, input logic fls);
        ex_valid  = v;
        ex_opcode = op;
        ex_result = res;
        ex_ovfl   = ovfl;
        ex_dst    = dst;
        ex_wr_en  = wr;
        stall     = stl;
        flush     = fls;
    endtask

    task automatic chk_all_zero(input string name, input int idx);
        chk({name, "_valid"}, idx, 16'(mem_valid), 16'h0);
        chk({name, "_op"},    idx, 16'(mem_opcode), 16'h0);
        chk({name, "_res"},   idx, mem_result, 16'h0);
        chk({name, "_dst"},   idx, 16'(mem_dst), 16'h0);
        chk({name, "_wr"},    idx, 16'(mem_wr_en), 16'h0);
        chk({name, "_zvn"},   idx, 16'({flag_z, flag_v, flag_n}), 16'h0);
    endtask

    initial begin
        logic [7:0] exp_sweep;
        exp_sweep = 8'b1011_0010;  // bit i = expected br_taken for ccc=i with Z=1,V=0,N=0

        //         v  op         res       ov dst wr st fl cd  ev e_op      e_res     e_dst e_wr zvn
        vecs[0]  = '{1, OP_ADD,    16'h0000, 1, 3, 1, 0, 0, 1, 1, OP_ADD, 16'h0000, 3, 1, 3'b110};
        vecs[1]  = '{1, OP_XOR,    16'h8000, 0, 4, 1, 0, 0, 1, 1, OP_XOR, 16'h8000, 4, 1, 3'b010};
        vecs[2]  = '{1, OP_SUB,    16'h8000, 0, 5, 1, 1, 0, 1, 1, OP_XOR, 16'h8000, 4, 1, 3'b010};
        vecs[3]  = '{1, OP_SUB,    16'h8000, 0, 5, 1, 1, 0, 1, 1, OP_XOR, 16'h8000, 4, 1, 3'b010};
        vecs[4]  = '{1, OP_SUB,    16'h8000, 0, 5, 1, 0, 0, 1, 1, OP_SUB, 16'h8000, 5, 1, 3'b001};
        vecs[5]  = '{1, OP_ADD,    16'h0000, 0, 6, 1, 1, 1, 1, 1, OP_SUB, 16'h8000, 5, 1, 3'b001};
        vecs[6]  = '{1, OP_ADD,    16'h0000, 0, 6, 1, 0, 1, 0, 0, OP_ADD, 16'h0000, 6, 0, 3'b001};
        vecs[7]  = '{1, OP_RED,    16'h0000, 1, 7, 1, 0, 0, 1, 1, OP_RED, 16'h0000, 7, 1, 3'b001};
        vecs[8]  = '{0, OP_ADD,    16'h0000, 1, 2, 1, 0, 0, 1, 0, OP_ADD, 16'h0000, 2, 0, 3'b001};
        vecs[9]  = '{1, OP_SLL,    16'h0000, 0, 1, 1, 0, 0, 1, 1, OP_SLL, 16'h0000, 1, 1, 3'b101};
        vecs[10] = '{1, OP_ADD,    16'h7FFF, 1, 1, 1, 0, 0, 1, 1, OP_ADD, 16'h7FFF, 1, 1, 3'b010};
        vecs[11] = '{1, OP_LW,     16'h0000, 0, 9, 1, 0, 0, 1, 1, OP_LW,  16'h0000, 9, 1, 3'b010};
        vecs[12] = '{1, OP_SW,     16'h0000, 0, 9, 0, 0, 0, 1, 1, OP_SW,  16'h0000, 9, 0, 3'b010};

        rst_n   = 1'b0;
        br_cond = CC_NE;
        drive(0, OP_ADD, 16'h0, 0, 0, 0, 0, 0);
        #12;
        chk_all_zero("reset", 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].op, vecs[i].res, vecs[i].ovfl, vecs[i].dst, vecs[i].wr,
                  vecs[i].stl, vecs[i].fls);
            @(posedge clk);
            #1;
            chk("valid", i, 16'(mem_valid), 16'(vecs[i].e_valid));
            chk("wr_en", i, 16'(mem_wr_en), 16'(vecs[i].e_wr));
            chk("zvn",   i, 16'({flag_z, flag_v, flag_n}), 16'(vecs[i].e_zvn));
            if (vecs[i].chk_data) begin
                chk("opcode", i, 16'(mem_opcode), 16'(vecs[i].e_op));
                chk("result", i, mem_result, vecs[i].e_res);
                chk("dst",    i, 16'(mem_dst), 16'(vecs[i].e_dst));
            end
        end

        // Establish Z=1 V=0 N=0, then sweep all condition codes
        @(negedge clk);
        drive(1, OP_ADD, 16'h0000, 0, 0, 1, 0, 0);
        @(negedge clk);
        drive(0, OP_ADD, 16'h0000, 0, 0, 0, 0, 0);
        chk("sweep_flags", 0, 16'({flag_z, flag_v, flag_n}), 16'b100);
        for (int c = 0; c < 8; c++) begin
            br_cond = 3'(c);
            #1;
            chk("br_sweep", c, 16'(br_taken), 16'(exp_sweep[c]));
        end

        // Branch in decode alongside a flag-setter in EX
        @(negedge clk);
        drive(1, OP_ADD, 16'h0001, 0, 0, 1, 0, 0);
        @(negedge clk);
        chk("byp_pre_z", 0, 16'(flag_z), 16'h0);
        drive(1, OP_SUB, 16'h0000, 0, 0, 1, 0, 0);
        br_cond = CC_EQ;
        #1;
`ifdef FLAG_BYPASS_EN
        chk("byp_same", 0, 16'(br_taken), 16'h1);
`else
        chk("byp_same", 0, 16'(br_taken), 16'h0);
`endif
        @(negedge clk);
        drive(0, OP_ADD, 16'h0000, 0, 0, 0, 0, 0);
        #1;
        chk("byp_next", 0, 16'(br_taken), 16'h1);

        // Drive flags to 111 with a valid slot, then reset asynchronously mid-stall
        @(negedge clk);
        drive(1, OP_ADD, 16'h8000, 1, 0, 1, 0, 0);
        @(negedge clk);
        drive(1, OP_XOR, 16'h0000, 0, 0, 1, 0, 0);
        @(negedge clk);
        drive(1, OP_ADD, 16'h1234, 0, 5, 1, 1, 0);
        chk("pre_rst_zvn",   0, 16'({flag_z, flag_v, flag_n}), 16'b111);
        chk("pre_rst_valid", 0, 16'(mem_valid), 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst", 1);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
